inst_fetch: RTL and testbench

Instruction fetch front end between the PC register and external instruction memory. It takes pc/pc_vld from the PC stage and issues single-word reads over a req/gnt/rvalid bus with variable latency. A one-entry line buffer holds the last fetched instruction. It drives inst_data/inst_vld into the IF/ID register and raises stall_req while a fetch is outstanding.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_timer.sv | 37 +++
 rtl/inst_fetch.sv | 176 +++++++++++++++++
 tb/tb_inst_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   INST_W           : instruction / address width
//   NOP_INST_DEFAULT : default instruction substituted on error or flush
//   fetch_state_e    : fetch controller states
//   is_word_aligned  : true when a byte address sits on a 32-bit word boundary
package fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [INST_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating cycle counter used to bound the time a fetch may stay outstanding.
//   clk   : clock
//   rst_  : synchronous reset, active-high
//   clr   : clear the count to zero (wins over en)
//   en    : count up by one, saturating at the counter maximum
//   tc    : terminal count, high while the count equals TIMEOUT-1
module fetch_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [9:0] TC_VAL  = 10'(TIMEOUT - 32'd1);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic [9:0] count_r;

    // Count cycles while enabled, saturating so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst_) begin
            count_r <= 10'd0;
        end else if (clr) begin
            count_r <= 10'd0;
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + 10'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end between the PC stage and instruction memory.
// Issues single-word reads over a req/gnt/rvalid bus and keeps the last
// fetched word in a one-entry line buffer that is looked up combinationally.
//   clk, rst_             : clock, synchronous active-high reset
//   pc, pc_vld            : fetch address from the PC stage
//   flush                 : drop the in-flight fetch and the buffer contents
//   inst_data/vld/err     : instruction toward IF/ID (err = misaligned or timeout)
//   stall_req             : PC stage must hold pc (miss outstanding)
//   mem_req, mem_addr     : read request to instruction memory
//   mem_gnt               : request accepted
//   mem_rvalid, mem_rdata : read response
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [INST_W-1:0]  NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [INST_W-1:0] pc,
    input  logic              pc_vld,
    input  logic              flush,
    output logic [INST_W-1:0] inst_data,
    output logic              inst_vld,
    output logic              inst_err,
    output logic              stall_req,
    output logic              mem_req,
    output logic [INST_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata
);

    fetch_state_e      state_r;
    logic [INST_W-1:0] addr_r;
    logic [INST_W-1:0] buf_data_r;
    logic [INST_W-1:0] tag_r;
    logic              buf_valid_r;
    logic              err_flag_r;
    logic              stale_pend_r;
    logic              mem_req_r;

    logic              aligned_s;
    logic              hit_s;
    logic              miss_s;
    logic              start_s;
    logic              timer_clr_s;
    logic              timer_en_s;
    logic              timeout_s;

    assign aligned_s = is_word_aligned(pc);
    assign hit_s     = pc_vld & buf_valid_r & (tag_r == pc);
    assign miss_s    = pc_vld & aligned_s & ~hit_s;
    // A stale response still owed by memory blocks any new request.
    assign start_s   = (state_r == FS_IDLE) & miss_s & ~stale_pend_r & ~flush;

    assign timer_clr_s = (state_r == FS_IDLE);
    assign timer_en_s  = (state_r != FS_IDLE);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk  (clk),
        .rst_ (rst_),
        .clr  (timer_clr_s),
        .en   (timer_en_s),
        .tc   (timeout_s)
    );

    // Fetch controller: request issue, response capture, timeout and flush handling.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_r      <= FS_IDLE;
            addr_r       <= 32'h0000_0000;
            buf_data_r   <= 32'h0000_0000;
            tag_r        <= 32'h0000_0000;
            buf_valid_r  <= 1'b0;
            err_flag_r   <= 1'b0;
            stale_pend_r <= 1'b0;
            mem_req_r    <= 1'b0;
        end else begin
            case (state_r)
                FS_IDLE: begin
                    if (flush) begin
                        buf_valid_r <= 1'b0;
                    end else if (start_s) begin
                        addr_r    <= pc;
                        mem_req_r <= 1'b1;
                        state_r   <= FS_REQ;
                    end
                    // The first response after an abandoned fetch belongs to it.
                    if (stale_pend_r && mem_rvalid) begin
                        stale_pend_r <= 1'b0;
                    end
                end
                FS_REQ: begin
                    if (flush) begin
                        buf_valid_r <= 1'b0;
                        mem_req_r   <= 1'b0;
                        state_r     <= FS_IDLE;
                        // Granted in the same cycle: a response is now owed.
                        if (mem_gnt) begin
                            stale_pend_r <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        buf_data_r  <= NOP_INST;
                        tag_r       <= addr_r;
                        buf_valid_r <= 1'b1;
                        err_flag_r  <= 1'b1;
                        mem_req_r   <= 1'b0;
                        state_r     <= FS_IDLE;
                        if (mem_gnt) begin
                            stale_pend_r <= 1'b1;
                        end
                    end else if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        state_r   <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (flush) begin
                        buf_valid_r <= 1'b0;
                        state_r     <= FS_IDLE;
                        // A response arriving with the flush is consumed here.
                        if (!mem_rvalid) begin
                            stale_pend_r <= 1'b1;
                        end
                    end else if (mem_rvalid) begin
                        buf_data_r  <= mem_rdata;
                        tag_r       <= addr_r;
                        buf_valid_r <= 1'b1;
                        err_flag_r  <= 1'b0;
                        state_r     <= FS_IDLE;
                    end else if (timeout_s) begin
                        buf_data_r   <= NOP_INST;
                        tag_r        <= addr_r;
                        buf_valid_r  <= 1'b1;
                        err_flag_r   <= 1'b1;
                        stale_pend_r <= 1'b1;
                        state_r      <= FS_IDLE;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= FS_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = addr_r;

    // Instruction-side outputs: same-cycle buffer lookup and misalignment check.
    always_comb begin
        inst_data = NOP_INST;
        inst_vld  = 1'b0;
        inst_err  = 1'b0;
        stall_req = 1'b0;
        if (rst_) begin
            inst_data = 32'h0000_0000;
        end else if (!pc_vld) begin
            inst_data = NOP_INST;
        end else if (!aligned_s) begin
            inst_vld = 1'b1;
            inst_err = 1'b1;
        end else if (hit_s) begin
            inst_data = buf_data_r;
            inst_vld  = 1'b1;
            inst_err  = err_flag_r;
        end else begin
            stall_req = 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst_;
    logic [31:0] pc;
    logic        pc_vld;
    logic        flush;
    logic [31:0] inst_data;
    logic        inst_vld;
    logic        inst_err;
    logic        stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int passed;
    int total;

    typedef struct {
        logic [31:0] pc;
        logic        pc_vld;
        logic        exp_vld;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[8];

    inst_fetch #(
        .TIMEOUT  (8),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .pc         (pc),
        .pc_vld     (pc_vld),
        .flush      (flush),
        .inst_data  (inst_data),
        .inst_vld   (inst_vld),
        .inst_err   (inst_err),
        .stall_req  (stall_req),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_out(input string name, input logic vld, input logic err,
                           input logic [31:0] data, input logic stall);
        chk({name, "_vld"},   {31'd0, inst_vld},  {31'd0, vld});
        chk({name, "_err"},   {31'd0, inst_err},  {31'd0, err});
        chk({name, "_data"},  inst_data,          data);
        chk({name, "_stall"}, {31'd0, stall_req}, {31'd0, stall});
    endtask

    // drive point: just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sample point: falling edge
    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_ = 1'b1; pc = 32'h0; pc_vld = 1'b0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        vecs[0] = '{32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h2401_0005, 1'b0};
        vecs[1] = '{32'h0000_0102, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[2] = '{32'h0000_0101, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_0103, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[4] = '{32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h0000_03FE, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h2401_0005, 1'b0};

        // reset state
        tick(); tick(); smp();
        chk_out("rst", 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        tick(); rst_ = 1'b0; smp();
        chk_out("idle", 1'b0, 1'b0, 32'h0, 1'b0);

        // zero-wait fetch of 0x100
        tick(); pc = 32'h100; pc_vld = 1'b1; smp();
        chk("t1_c0_stall", {31'd0, stall_req}, 32'd1);
        chk("t1_c0_req", {31'd0, mem_req}, 32'd0);
        tick(); mem_gnt = 1'b1; smp();
        chk("t1_c1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_c1_addr", mem_addr, 32'h100);
        chk("t1_c1_stall", {31'd0, stall_req}, 32'd1);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2401_0005; smp();
        chk("t1_c2_req", {31'd0, mem_req}, 32'd0);
        chk_out("t1_c2", 1'b0, 1'b0, 32'h0, 1'b1);
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; smp();
        chk_out("t1_c3_hit", 1'b1, 1'b0, 32'h2401_0005, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); smp();
            chk("t1_no_req", {31'd0, mem_req}, 32'd0);
            chk("t1_hold_vld", {31'd0, inst_vld}, 32'd1);
        end

        // table: hits, misaligned, idle
        for (int i = 0; i < 8; i++) begin
            tick(); pc = vecs[i].pc; pc_vld = vecs[i].pc_vld; smp();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_err,
                    vecs[i].exp_data, vecs[i].exp_stall);
            chk($sformatf("vec%0d_req", i), {31'd0, mem_req}, 32'd0);
        end

        // gnt after 2 cycles, rvalid 3 cycles after gnt
        for (int c = 0; c < 8; c++) begin
            tick();
            pc = 32'h104; pc_vld = 1'b1;
            mem_gnt    = (c == 3);
            mem_rvalid = (c == 6);
            mem_rdata  = (c == 6) ? 32'h8C22_0004 : 32'h0;
            smp();
            if (c < 7) begin
                chk($sformatf("t2_c%0d_stall", c), {31'd0, stall_req}, 32'd1);
                chk($sformatf("t2_c%0d_req", c), {31'd0, mem_req},
                    ((c >= 1) && (c <= 3)) ? 32'd1 : 32'd0);
                if ((c >= 1) && (c <= 3)) chk($sformatf("t2_c%0d_addr", c), mem_addr, 32'h104);
            end else begin
                chk_out("t2_hit", 1'b1, 1'b0, 32'h8C22_0004, 1'b0);
            end
        end
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // timeout after 8 cycles in REQ+WAIT, then stale response
        for (int c = 0; c < 10; c++) begin
            tick();
            pc = 32'h180; pc_vld = 1'b1;
            mem_gnt = (c == 1);
            smp();
            if (c < 9) begin
                chk($sformatf("t4_c%0d_stall", c), {31'd0, stall_req}, 32'd1);
            end else begin
                chk_out("t4_to_hit", 1'b1, 1'b1, 32'h0, 1'b0);
                chk("t4_to_req", {31'd0, mem_req}, 32'd0);
            end
        end
        mem_gnt = 1'b0;
        tick(); pc = 32'h108; smp();
        chk("t4_c10_stall", {31'd0, stall_req}, 32'd1);
        chk("t4_c10_req", {31'd0, mem_req}, 32'd0);
        tick(); smp();
        chk("t4_c11_req", {31'd0, mem_req}, 32'd0);
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; smp();
        chk("t4_c12_req", {31'd0, mem_req}, 32'd0);
        chk_out("t4_c12", 1'b0, 1'b0, 32'h0, 1'b1);
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; smp();
        chk("t4_c13_req", {31'd0, mem_req}, 32'd0);
        chk("t4_c13_stall", {31'd0, stall_req}, 32'd1);
        tick(); mem_gnt = 1'b1; smp();
        chk("t4_c14_req", {31'd0, mem_req}, 32'd1);
        chk("t4_c14_addr", mem_addr, 32'h108);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_0000; smp();
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; smp();
        chk_out("t4_hit", 1'b1, 1'b0, 32'h1111_0000, 1'b0);

        // flush coinciding with rvalid in WAIT
        tick(); pc = 32'h200; smp();
        chk("t5_c0_stall", {31'd0, stall_req}, 32'd1);
        tick(); mem_gnt = 1'b1; smp();
        chk("t5_c1_req", {31'd0, mem_req}, 32'd1);
        chk("t5_c1_addr", mem_addr, 32'h200);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA; flush = 1'b1; smp();
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; flush = 1'b0; smp();
        chk_out("t5_c3", 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_c3_req", {31'd0, mem_req}, 32'd0);
        tick(); mem_gnt = 1'b1; smp();
        chk("t5_c4_req", {31'd0, mem_req}, 32'd1);
        chk("t5_c4_addr", mem_addr, 32'h200);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234; smp();
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; smp();
        chk_out("t5_hit", 1'b1, 1'b0, 32'h0000_1234, 1'b0);

        // flush in REQ retracts the request without a stale wait
        tick(); pc = 32'h400; smp();
        tick(); flush = 1'b1; smp();
        chk("t7_c1_req", {31'd0, mem_req}, 32'd1);
        tick(); flush = 1'b0; smp();
        chk("t7_c2_req", {31'd0, mem_req}, 32'd0);
        chk("t7_c2_stall", {31'd0, stall_req}, 32'd1);
        tick(); mem_gnt = 1'b1; smp();
        chk("t7_c3_req", {31'd0, mem_req}, 32'd1);
        chk("t7_c3_addr", mem_addr, 32'h400);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D; smp();
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; smp();
        chk_out("t7_hit", 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0);

        // reset in WAIT, response never arrives
        tick(); pc = 32'h300; smp();
        tick(); mem_gnt = 1'b1; smp();
        tick(); mem_gnt = 1'b0; rst_ = 1'b1; pc_vld = 1'b0; smp();
        tick(); rst_ = 1'b0; smp();
        chk_out("t6_after_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_req", {31'd0, mem_req}, 32'd0);
        chk("t6_addr", mem_addr, 32'h0);
        tick(); pc = 32'h400; pc_vld = 1'b1; smp();
        chk_out("t6_miss", 1'b0, 1'b0, 32'h0, 1'b1);
        tick(); mem_gnt = 1'b1; smp();
        chk("t6_new_req", {31'd0, mem_req}, 32'd1);
        chk("t6_new_addr", mem_addr, 32'h400);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AA; smp();
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; smp();
        chk_out("t6_hit", 1'b1, 1'b0, 32'h0000_00AA, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
